// File: rtl/pin_event_capture.sv
// Edge-event capture on synchronized pins, queued in a small FIFO.
// Ports: clock_80/nres, sync_in, rise/fall masks, evt_* head + handshake,
// level, sticky overflow with clr_ovf.
// Option: `define PIN_EVENT_TIMESTAMP_EN to store a cycle timestamp per entry.
module pin_event_capture #(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 32
) (
  input  logic                     clock_80,
  input  logic                     nres,
  input  logic [31:0]              sync_in,
  input  logic [31:0]              rise_mask,
  input  logic [31:0]              fall_mask,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [31:0]              evt_pins,
  output logic [31:0]              evt_change,
  output logic [TS_WIDTH-1:0]      evt_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0] r_prev;
  logic        r_primed;
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_ovf;
  logic [31:0] r_pins [DEPTH];
  logic [31:0] r_chg  [DEPTH];

  logic [31:0] w_edges;
  logic        w_hit;
  logic [AW:0] w_level;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  assign w_edges = (sync_in & ~r_prev & rise_mask)
                 | (~sync_in & r_prev & fall_mask);
  assign w_hit   = r_primed & (|w_edges);
  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == FULL);
  assign w_pop   = evt_valid & evt_ready;
  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign w_push  = w_hit & (~w_full | w_pop);
  assign w_drop  = w_hit & w_full & ~w_pop;

  assign evt_valid  = (w_level != '0);
  assign level      = w_level;
  assign overflow   = r_ovf;
  assign evt_pins   = r_pins[r_rptr[AW-1:0]];
  assign evt_change = r_chg[r_rptr[AW-1:0]];

  always_ff @(posedge clock_80 or negedge nres) begin
    if (!nres) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pins[i] <= '0;
        r_chg[i]  <= '0;
      end
    end else begin
      r_prev   <= sync_in;
      r_primed <= 1'b1;
      if (w_push) begin
        r_pins[r_wptr[AW-1:0]] <= sync_in;
        r_chg[r_wptr[AW-1:0]]  <= w_edges;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      // Set wins over clear.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef PIN_EVENT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_tsm [DEPTH];

  always_ff @(posedge clock_80 or negedge nres) begin
    if (!nres) begin
      r_ts <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tsm[i] <= '0;
      end
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (w_push) begin
        r_tsm[r_wptr[AW-1:0]] <= r_ts;
      end
    end
  end

  assign evt_ts = r_tsm[r_rptr[AW-1:0]];
`else
  assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_pin_event_capture.sv
// Scoreboard bench for pin_event_capture.
// Directed edge stimulus; a negedge monitor compares every popped entry.
module tb_pin_event_capture;

  localparam int DEPTH = 4;
  localparam int TSW   = 4;

  typedef struct packed {
    logic [31:0]    pins;
    logic [31:0]    chg;
    logic [TSW-1:0] ts;
  } ent_t;

  logic            clk = 1'b0;
  logic            nres;
  logic [31:0]     sync_in;
  logic [31:0]     rise_mask;
  logic [31:0]     fall_mask;
  logic            evt_valid;
  logic            evt_ready;
  logic [31:0]     evt_pins;
  logic [31:0]     evt_change;
  logic [TSW-1:0]  evt_ts;
  logic [2:0]      level;
  logic            overflow;
  logic            clr_ovf;

  int   checks   = 0;
  int   failures = 0;
  ent_t q[$];
  logic [31:0] cyc;

  always #5 clk = ~clk;

  pin_event_capture #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clock_80  (clk),
    .nres      (nres),
    .sync_in   (sync_in),
    .rise_mask (rise_mask),
    .fall_mask (fall_mask),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_pins  (evt_pins),
    .evt_change(evt_change),
    .evt_ts    (evt_ts),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // Cycles elapsed since reset release: the timestamp the DUT should hold.
  always @(posedge clk or negedge nres) begin
    if (!nres) cyc <= '0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [TSW-1:0] ets();
`ifdef PIN_EVENT_TIMESTAMP_EN
    return cyc[TSW-1:0];
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nres && evt_valid && evt_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got pins=%h chg=%h expected none",
                 evt_pins, evt_change);
      end else begin
        ent_t e;
        e = q.pop_front();
        if (evt_pins !== e.pins || evt_change !== e.chg || evt_ts !== e.ts) begin
          failures++;
          $display("FAIL pop_entry: got %h/%h/%h expected %h/%h/%h",
                   evt_pins, evt_change, evt_ts, e.pins, e.chg, e.ts);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] pins, input bit exp,
                    input logic [31:0] chg);
    sync_in = pins;
    if (exp) q.push_back('{pins: pins, chg: chg, ts: ets()});
    tick();
  endtask

  task automatic drain(input int n);
    evt_ready = 1'b1;
    repeat (n) tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    int n;
    nres      = 1'b1;
    sync_in   = '1;
    rise_mask = '1;
    fall_mask = '1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    #1 nres = 1'b0;
    #2;
    chk("rst_valid", {31'b0, evt_valid}, 32'h0);
    chk("rst_level", {29'b0, level}, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    chk("rst_pins", evt_pins, 32'h0);
    chk("rst_chg", evt_change, 32'h0);
    chk("rst_ts", {28'b0, evt_ts}, 32'h0);
    tick();
    tick();
    nres = 1'b1;
    repeat (3) tick();
    chk("prime_level", {29'b0, level}, 32'h0);
    chk("prime_valid", {31'b0, evt_valid}, 32'h0);

    rise_mask = 32'h1;
    fall_mask = 32'h0;
    ev(32'h0, 0, 0);
    chk("nofall_level", {29'b0, level}, 32'h0);
    ev(32'h1, 1, 32'h1);
    chk("lat_valid", {31'b0, evt_valid}, 32'h1);
    chk("lat_level", {29'b0, level}, 32'h1);
    ev(32'h0, 0, 0);
    chk("mfall_level", {29'b0, level}, 32'h1);
    drain(1);
    chk("pop1_valid", {31'b0, evt_valid}, 32'h0);

    rise_mask = 32'h88;
    fall_mask = 32'h88;
    ev(32'h88, 1, 32'h88);
    ev(32'h80, 1, 32'h08);
    chk("two_level", {29'b0, level}, 32'h2);
    rise_mask = '1;
    fall_mask = '1;
    tick();
    tick();
    chk("maskchg_level", {29'b0, level}, 32'h2);
    drain(2);
    chk("drain2_level", {29'b0, level}, 32'h0);

    ev(32'h0, 1, 32'h80);
    ev(32'h1, 1, 32'h1);
    ev(32'h3, 1, 32'h2);
    ev(32'h7, 1, 32'h4);
    chk("full_level", {29'b0, level}, 32'h4);
    chk("full_noovf", {31'b0, overflow}, 32'h0);
    ev(32'hF, 0, 32'h8);
    chk("ovf_level", {29'b0, level}, 32'h4);
    chk("ovf_set", {31'b0, overflow}, 32'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", {31'b0, overflow}, 32'h0);
    clr_ovf = 1'b1;
    ev(32'hE, 0, 32'h1);
    clr_ovf = 1'b0;
    chk("ovf_prio", {31'b0, overflow}, 32'h1);
    chk("ovf_prio_lvl", {29'b0, level}, 32'h4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr2", {31'b0, overflow}, 32'h0);

    evt_ready = 1'b1;
    ev(32'hC, 1, 32'h2);
    evt_ready = 1'b0;
    chk("fullpp_level", {29'b0, level}, 32'h4);
    chk("fullpp_noovf", {31'b0, overflow}, 32'h0);
    drain(4);
    chk("drain4_level", {29'b0, level}, 32'h0);
    chk("drain4_valid", {31'b0, evt_valid}, 32'h0);

    n = 0;
    while (cyc[TSW-1:0] != 4'hF && n < 20) begin
      tick();
      n++;
    end
    chk("wrap_align", {28'b0, cyc[TSW-1:0]}, 32'hF);
    ev(32'hD, 1, 32'h1);
    tick();
    ev(32'hC, 1, 32'h1);
    drain(2);
    chk("wrap_level", {29'b0, level}, 32'h0);

    ev(32'h8, 1, 32'h4);
    ev(32'h0, 1, 32'h8);
    ev(32'h1, 1, 32'h1);
    chk("q3_level", {29'b0, level}, 32'h3);
    nres = 1'b0;
    #1;
    chk("rstmid_valid", {31'b0, evt_valid}, 32'h0);
    chk("rstmid_level", {29'b0, level}, 32'h0);
    chk("rstmid_pins", evt_pins, 32'h0);
    q.delete();
    tick();
    nres = 1'b1;
    repeat (3) tick();
    chk("rel_level", {29'b0, level}, 32'h0);

    chk("sb_empty", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
